lenet_argmax: RTL and testbench

//  Final classification stage after fc_top. On fc2_done it reads the 10 signed 8-bit FC2 scores from SRAM f.
//  It returns the winning class index, the winning score and the margin over the runner-up on a valid/ready port.
//  It also raises a low-confidence flag when the margin is below a threshold.

---
 rtl/lenet_pkg.sv | 28 ++
 rtl/argmax_merge4.sv | 39 +++
 rtl/lenet_argmax.sv | 139 +++++++++++++
 tb/tb_lenet_argmax.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared constants and FSM state type for the LeNet final classification stage.
// Scores are signed bytes packed four to an SRAM f word, lowest class in the top byte.
package lenet_pkg;

    localparam int SCORE_WIDTH    = 8;
    localparam int NUM_CLASS      = 10;
    localparam int SRAM_F_WORDS   = 3;
    localparam int BYTES_PER_WORD = 4;

    localparam int WORD_WIDTH   = SCORE_WIDTH * BYTES_PER_WORD;
    localparam int MARGIN_WIDTH = SCORE_WIDTH + 1;
    localparam int CLASS_WIDTH  = 4;
    localparam int ADDR_WIDTH   = 2;

    // The last word only carries the classes left over after the full words.
    localparam int LAST_BYTES = NUM_CLASS - BYTES_PER_WORD * (SRAM_F_WORDS - 1);
    localparam logic [BYTES_PER_WORD-1:0] LAST_MASK = BYTES_PER_WORD'((1 << LAST_BYTES) - 1);

    localparam logic signed [SCORE_WIDTH-1:0] SCORE_MIN = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } argmax_state_e;

endpackage

// File: rtl/argmax_merge4.sv
// Folds up to four class scores into the running best/second-best pair.
// Bytes are visited in ascending class order so a tie on best keeps the lower index.
module argmax_merge4
    import lenet_pkg::*;
(
    input  logic signed [SCORE_WIDTH-1:0]              i_best,
    input  logic signed [SCORE_WIDTH-1:0]              i_second,
    input  logic [CLASS_WIDTH-1:0]                     i_bestIdx,
    input  logic [BYTES_PER_WORD-1:0][SCORE_WIDTH-1:0] i_scores,
    input  logic [CLASS_WIDTH-1:0]                     i_baseIdx,
    input  logic [BYTES_PER_WORD-1:0]                  i_mask,
    output logic signed [SCORE_WIDTH-1:0]              o_best,
    output logic signed [SCORE_WIDTH-1:0]              o_second,
    output logic [CLASS_WIDTH-1:0]                     o_bestIdx
);

    logic signed [SCORE_WIDTH-1:0] w_cand;

    // An equal score never displaces best; it can only raise second.
    always_comb begin
        o_best    = i_best;
        o_second  = i_second;
        o_bestIdx = i_bestIdx;
        w_cand    = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            w_cand = i_scores[k];
            if (i_mask[k]) begin
                if (w_cand > o_best) begin
                    o_second  = o_best;
                    o_best    = w_cand;
                    o_bestIdx = i_baseIdx + CLASS_WIDTH'(k);
                end else if (w_cand > o_second) begin
                    o_second = w_cand;
                end
            end
        end
    end

endmodule

// File: rtl/lenet_argmax.sv
// Final classification stage: reads the FC2 scores from SRAM f after fc2_done and
// presents the winning class, score and margin over the runner-up on a valid/ready port.
module lenet_argmax
    import lenet_pkg::*;
#(
    parameter int MARGIN_THRESH = 8
) (
    input  logic                    clk,
    input  logic                    srstn,
    input  logic                    fc2_done,
    output logic [ADDR_WIDTH-1:0]   sram_raddr_f,
    input  logic [WORD_WIDTH-1:0]   sram_rdata_f,
    output logic                    busy,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [CLASS_WIDTH-1:0]  result_class,
    output logic [SCORE_WIDTH-1:0]  result_score,
    output logic [MARGIN_WIDTH-1:0] result_margin,
    output logic                    low_conf
);

    argmax_state_e                     r_state;
    logic [ADDR_WIDTH-1:0]             r_addrCnt;
    logic                              r_rdVld;
    logic [ADDR_WIDTH-1:0]             r_rdAddr;
    logic signed [SCORE_WIDTH-1:0]     r_best;
    logic signed [SCORE_WIDTH-1:0]     r_second;
    logic [CLASS_WIDTH-1:0]            r_bestIdx;
    logic                              r_resultValid;
    logic [CLASS_WIDTH-1:0]            r_resultClass;
    logic [SCORE_WIDTH-1:0]            r_resultScore;
    logic [MARGIN_WIDTH-1:0]           r_resultMargin;
    logic                              r_lowConf;

    logic [BYTES_PER_WORD-1:0][SCORE_WIDTH-1:0] w_scores;
    logic [BYTES_PER_WORD-1:0]                  w_mask;
    logic [CLASS_WIDTH-1:0]                     w_baseIdx;
    logic signed [SCORE_WIDTH-1:0]              w_best;
    logic signed [SCORE_WIDTH-1:0]              w_second;
    logic [CLASS_WIDTH-1:0]                     w_bestIdx;
    logic [MARGIN_WIDTH-1:0]                    w_margin;

    always_comb begin
        w_scores = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            w_scores[k] = sram_rdata_f[WORD_WIDTH-1-SCORE_WIDTH*k -: SCORE_WIDTH];
        end
    end

    assign w_mask    = (r_rdAddr == ADDR_WIDTH'(SRAM_F_WORDS - 1)) ? LAST_MASK : '1;
    assign w_baseIdx = {r_rdAddr, 2'b00};

    argmax_merge4 u_merge (
        .i_best    (r_best),
        .i_second  (r_second),
        .i_bestIdx (r_bestIdx),
        .i_scores  (w_scores),
        .i_baseIdx (w_baseIdx),
        .i_mask    (w_mask),
        .o_best    (w_best),
        .o_second  (w_second),
        .o_bestIdx (w_bestIdx)
    );

    // best >= second always holds, so the sign-extended difference fits unsigned.
    assign w_margin = {w_best[SCORE_WIDTH-1], w_best} - {w_second[SCORE_WIDTH-1], w_second};

    // DRAIN is the cycle the last word is merged, so results are taken straight from the merger.
    always_ff @(posedge clk or posedge srstn) begin
        if (srstn) begin
            r_state        <= IDLE;
            r_addrCnt      <= '0;
            r_rdVld        <= 1'b0;
            r_rdAddr       <= '0;
            r_best         <= SCORE_MIN;
            r_second       <= SCORE_MIN;
            r_bestIdx      <= '0;
            r_resultValid  <= 1'b0;
            r_resultClass  <= '0;
            r_resultScore  <= '0;
            r_resultMargin <= '0;
            r_lowConf      <= 1'b0;
        end else begin
            r_rdVld  <= (r_state == ISSUE);
            r_rdAddr <= r_addrCnt;
            if (r_rdVld) begin
                r_best    <= w_best;
                r_second  <= w_second;
                r_bestIdx <= w_bestIdx;
            end
            case (r_state)
                IDLE: begin
                    if (fc2_done) begin
                        r_state   <= ISSUE;
                        r_addrCnt <= '0;
                        r_best    <= SCORE_MIN;
                        r_second  <= SCORE_MIN;
                        r_bestIdx <= '0;
                    end
                end
                ISSUE: begin
                    r_addrCnt <= r_addrCnt + 1'b1;
                    if (r_addrCnt == ADDR_WIDTH'(SRAM_F_WORDS - 1)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_state        <= DONE;
                    r_addrCnt      <= '0;
                    r_resultValid  <= 1'b1;
                    r_resultClass  <= w_bestIdx;
                    r_resultScore  <= w_best;
                    r_resultMargin <= w_margin;
                    r_lowConf      <= (w_margin < MARGIN_WIDTH'(MARGIN_THRESH));
                end
                DONE: begin
                    if (result_ready) begin
                        r_state        <= IDLE;
                        r_resultValid  <= 1'b0;
                        r_resultClass  <= '0;
                        r_resultScore  <= '0;
                        r_resultMargin <= '0;
                        r_lowConf      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sram_raddr_f  = (r_state == ISSUE) ? r_addrCnt : '0;
    assign busy          = (r_state != IDLE);
    assign result_valid  = r_resultValid;
    assign result_class  = r_resultClass;
    assign result_score  = r_resultScore;
    assign result_margin = r_resultMargin;
    assign low_conf      = r_lowConf;

endmodule

// File: tb/tb_lenet_argmax.sv
// Self-checking bench for lenet_argmax: an SRAM f model feeds score vectors and a
// reference argmax pushes expected results to a queue that is drained as results appear.
`timescale 1ns/1ps
module tb_lenet_argmax;

    logic        clk = 1'b0;
    logic        srstn;
    logic        fc2_done;
    logic [1:0]  sram_raddr_f;
    logic [31:0] sram_rdata_f;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [3:0]  result_class;
    logic [7:0]  result_score;
    logic [8:0]  result_margin;
    logic        low_conf;

    typedef struct packed {
        logic [3:0] cls;
        logic [7:0] score;
        logic [8:0] margin;
        logic       lowConf;
    } result_t;

    result_t expQ[$];
    int      scores[10];
    logic [31:0] mem [0:2];
    int      errors = 0;
    int      checks = 0;

    lenet_argmax dut (
        .clk           (clk),
        .srstn         (srstn),
        .fc2_done      (fc2_done),
        .sram_raddr_f  (sram_raddr_f),
        .sram_rdata_f  (sram_rdata_f),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_class  (result_class),
        .result_score  (result_score),
        .result_margin (result_margin),
        .low_conf      (low_conf)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data appears one cycle after the address.
    always @(posedge clk) sram_rdata_f <= mem[sram_raddr_f];

    function automatic result_t model();
        result_t r;
        int bi = 0;
        int second = -128;
        for (int i = 1; i < 10; i++) if (scores[i] > scores[bi]) bi = i;
        for (int i = 0; i < 10; i++) if (i != bi && scores[i] > second) second = scores[i];
        r.cls     = 4'(bi);
        r.score   = 8'(scores[bi]);
        r.margin  = 9'(scores[bi] - second);
        r.lowConf = ((scores[bi] - second) < 8);
        return r;
    endfunction

    function automatic string fmt(result_t r);
        return $sformatf("cls=%0d score=%0d margin=%0d low=%0b", r.cls, $signed(r.score), r.margin, r.lowConf);
    endfunction

    function automatic result_t observed();
        return {result_class, result_score, result_margin, low_conf};
    endfunction

    // Loads SRAM f from scores[], optionally queues the expected result, and pulses fc2_done.
    // Entered on a negedge (cycle 0); returns on the negedge of cycle 1.
    task automatic applyStimulus(input logic [7:0] pad, input bit push);
        for (int a = 0; a < 3; a++) begin
            for (int k = 0; k < 4; k++) begin
                mem[a][31-8*k -: 8] = (4*a + k < 10) ? 8'(scores[4*a + k]) : pad;
            end
        end
        if (push) expQ.push_back(model());
        fc2_done = 1'b1;
        @(negedge clk);
        fc2_done = 1'b0;
    endtask

    task automatic waitResult(input int startCyc, output result_t obs, output result_t exp, output int lat);
        int n = startCyc;
        lat = -1;
        while (n < 20) begin
            if (result_valid === 1'b1) begin
                lat = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        obs = observed();
        exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
    endtask

    task automatic acceptResult();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        srstn = 1'b1; fc2_done = 1'b0; result_ready = 1'b0;
        for (int a = 0; a < 3; a++) mem[a] = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({result_valid, result_class, result_score, result_margin, low_conf, busy, sram_raddr_f} !== '0) begin
            errors++; $display("[TB] FAIL reset_outputs: got valid=%0b busy=%0b %s, expected all 0", result_valid, busy, fmt(observed()));
        end
        srstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({result_valid, busy, sram_raddr_f} !== '0) begin
            errors++; $display("[TB] FAIL reset_idle: got valid=%0b busy=%0b addr=%0d, expected 0", result_valid, busy, sram_raddr_f);
        end
    endtask

    task automatic test_basic();
        result_t obs, exp;
        int lat;
        scores = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 50};
        applyStimulus(8'h00, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (sram_raddr_f !== ((c < 4) ? 2'(c - 1) : 2'd0) || busy !== 1'b1 || result_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL basic_addr_c%0d: got addr=%0d busy=%0b valid=%0b, expected addr=%0d busy=1 valid=0", c, sram_raddr_f, busy, result_valid, (c < 4) ? c - 1 : 0);
            end
            if (c < 4) @(negedge clk);
        end
        waitResult(4, obs, exp, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("[TB] FAIL basic_latency: got %0d, expected 5", lat); end
        checks++;
        if (obs !== exp || exp !== result_t'({4'd9, 8'd50, 9'd41, 1'b0})) begin
            errors++; $display("[TB] FAIL basic_result: got %s, expected %s", fmt(obs), fmt(exp));
        end
        acceptResult();
        checks++;
        if ({result_valid, busy, observed()} !== '0) begin
            errors++; $display("[TB] FAIL basic_clear: got valid=%0b busy=%0b %s, expected all 0", result_valid, busy, fmt(observed()));
        end
    endtask

    task automatic test_all_min();
        result_t obs, exp;
        int lat;
        foreach (scores[i]) scores[i] = -128;
        applyStimulus(8'h7f, 1'b1);
        waitResult(1, obs, exp, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("[TB] FAIL allmin_latency: got %0d, expected 5", lat); end
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL allmin_result: got %s, expected %s", fmt(obs), fmt(exp)); end
        acceptResult();
    endtask

    task automatic test_ties();
        result_t obs, exp;
        int lat;
        foreach (scores[i]) scores[i] = 0;
        scores[3] = 20; scores[7] = 20;
        applyStimulus(8'h00, 1'b1);
        waitResult(1, obs, exp, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("[TB] FAIL ties_latency: got %0d, expected 5", lat); end
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL ties_result: got %s, expected %s", fmt(obs), fmt(exp)); end
        acceptResult();
    endtask

    task automatic test_negatives_hold();
        result_t obs, exp, held;
        int lat;
        bit sawActivity = 1'b0;
        foreach (scores[i]) scores[i] = -100;
        scores[5] = -1;
        applyStimulus(8'h00, 1'b1);
        waitResult(1, obs, exp, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("[TB] FAIL neg_latency: got %0d, expected 5", lat); end
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL neg_result: got %s, expected %s", fmt(obs), fmt(exp)); end
        held = exp;
        for (int i = 0; i < 10; i++) begin
            fc2_done = (i == 3);
            @(negedge clk);
            checks++;
            if (observed() !== held || result_valid !== 1'b1 || busy !== 1'b1) begin
                errors++; $display("[TB] FAIL neg_hold_%0d: got valid=%0b %s, expected valid=1 %s", i, result_valid, fmt(observed()), fmt(held));
            end
        end
        fc2_done = 1'b1;
        acceptResult();
        fc2_done = 1'b0;
        checks++;
        if ({result_valid, observed()} !== '0) begin
            errors++; $display("[TB] FAIL neg_clear: got valid=%0b %s, expected all 0", result_valid, fmt(observed()));
        end
        for (int i = 0; i < 8; i++) begin
            if (busy !== 1'b0 || result_valid !== 1'b0) sawActivity = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (sawActivity) begin errors++; $display("[TB] FAIL neg_ignored_pulse: got a scan after ignored fc2_done, expected none"); end
    endtask

    task automatic test_back_to_back();
        result_t obs, exp;
        int lat;
        foreach (scores[i]) scores[i] = i * 3;
        scores[6] = 100;
        applyStimulus(8'h00, 1'b1);
        waitResult(1, obs, exp, lat);
        checks++;
        if (obs !== exp || lat !== 5) begin errors++; $display("[TB] FAIL b2b_first: got %s lat=%0d, expected %s lat=5", fmt(obs), lat, fmt(exp)); end
        acceptResult();
        foreach (scores[i]) scores[i] = -50;
        scores[2] = -10; scores[8] = -20;
        applyStimulus(8'h00, 1'b1);
        waitResult(1, obs, exp, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("[TB] FAIL b2b_latency: got %0d, expected 5", lat); end
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL b2b_second: got %s, expected %s", fmt(obs), fmt(exp)); end
        acceptResult();
    endtask

    task automatic test_reset_mid_scan();
        result_t obs, exp;
        int lat;
        foreach (scores[i]) scores[i] = 10 - i;
        applyStimulus(8'h00, 1'b0);
        repeat (2) @(negedge clk);
        srstn = 1'b1;
        #1;
        checks++;
        if ({result_valid, busy, sram_raddr_f, observed()} !== '0) begin
            errors++; $display("[TB] FAIL midreset_outputs: got valid=%0b busy=%0b addr=%0d, expected 0", result_valid, busy, sram_raddr_f);
        end
        @(negedge clk);
        srstn = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({result_valid, busy} !== '0) begin
            errors++; $display("[TB] FAIL midreset_discard: got valid=%0b busy=%0b, expected 0", result_valid, busy);
        end
        foreach (scores[i]) scores[i] = i - 20;
        scores[4] = 30;
        applyStimulus(8'h00, 1'b1);
        waitResult(1, obs, exp, lat);
        checks++;
        if (obs !== exp || lat !== 5) begin errors++; $display("[TB] FAIL midreset_rescan: got %s lat=%0d, expected %s lat=5", fmt(obs), lat, fmt(exp)); end
        acceptResult();
    endtask

    task automatic test_random();
        result_t obs, exp;
        int lat;
        for (int t = 0; t < 6; t++) begin
            foreach (scores[i]) scores[i] = int'($urandom_range(0, 255)) - 128;
            applyStimulus(8'($urandom_range(0, 255)), 1'b1);
            waitResult(1, obs, exp, lat);
            checks++;
            if (obs !== exp || lat !== 5) begin errors++; $display("[TB] FAIL random_%0d: got %s lat=%0d, expected %s lat=5", t, fmt(obs), lat, fmt(exp)); end
            acceptResult();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_min();
        test_ties();
        test_negatives_hold();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
